async_req_issuer: RTL and testbench
===================================

ASYNC_REQ_ISSUER -- requirements
Module: async_req_issuer

Interface
REQ-001 Parameter DEPTH, default 4, FIFO entries; power of two, >= 2.
REQ-002 Parameter MIN_GAP, default 1, idle cycles forced between consecutive request pulses (0 = back-to-back allowed).
REQ-003 clk  input  1  single clock; all state SHALL update on posedge clk only.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 in_valid  input  1  upstream command valid.
REQ-006 in_data  input  32  upstream command payload.
REQ-007 in_ready  output  1  block can accept a command this cycle.
REQ-008 stall  input  1  downstream hold; blocks new issues while high.
REQ-009 request  output  1  registered one-cycle issue pulse to the downstream adder stage.
REQ-010 input_data  output  32  registered payload accompanying request.
REQ-011 fifo_count  output  $clog2(DEPTH+1)  current FIFO occupancy.
REQ-012 issued_count  output  16  total requests issued since reset.

Function
REQ-013 Push SHALL occur on a clk edge where in_valid && in_ready; in_data written at FIFO tail.
REQ-014 in_ready SHALL equal (fifo_count < DEPTH), combinational from registered count only, independent of same-cycle pop.
REQ-015 in_valid while in_ready low: command SHALL be ignored and not stored; in_data SHALL have no effect.
REQ-016 Issue condition SHALL be: fifo_count != 0 && !stall && gap_cnt == 0, evaluated from registered state in the current cycle.
REQ-017 On an edge with issue condition true: request <= 1, input_data <= FIFO head, head popped, issued_count += 1, gap_cnt <= MIN_GAP.
REQ-018 On any other edge: request <= 0, input_data SHALL hold its previous value.
REQ-019 gap_cnt SHALL decrement by 1 each edge while nonzero and not reloaded; it SHALL decrement regardless of stall.
REQ-020 No fall-through: a command pushed at edge N SHALL produce request high no earlier than after edge N+1.
REQ-021 Minimum push-to-request latency SHALL be 1 cycle (push at edge N into empty FIFO, stall low, gap 0 -> request high in cycle after edge N+1).
REQ-022 Simultaneous push and pop on one edge: fifo_count unchanged; both operations SHALL take effect.
REQ-023 Commands SHALL issue in strict FIFO order; none dropped or duplicated.
REQ-024 Read/write pointers SHALL wrap modulo DEPTH; full and empty distinguished by fifo_count, not pointer equality.
REQ-025 issued_count SHALL wrap 0xFFFF -> 0x0000 silently.
REQ-026 request SHALL never be high on two consecutive cycles when MIN_GAP >= 1; with MIN_GAP = 0, back-to-back pulses SHALL occur while FIFO non-empty and stall low.
REQ-027 stall asserted during a cycle where issue condition would otherwise hold: no issue; head entry retained; issue resumes on first edge with stall low and gap 0.
REQ-028 Controller states: IDLE (empty or stalled, gap 0), ISSUE (request pulse cycle), GAP (gap_cnt != 0); ISSUE -> GAP if MIN_GAP > 0, else ISSUE/IDLE per REQ-016; GAP -> IDLE or ISSUE when gap_cnt reaches 0.

Reset
REQ-029 reset high at an edge SHALL force: request 0, input_data 0x00000000, fifo_count 0, issued_count 0, gap_cnt 0, pointers 0, state IDLE.
REQ-030 Reset SHALL take priority over push and issue on the same edge; FIFO contents discarded (mid-operation flush).
REQ-031 in_ready SHALL be 1 in the first cycle after reset deasserts.

Verification
REQ-032 Single command: reset, push 0x00000010, stall 0, MIN_GAP 1 -> request=1, input_data=0x00000010 exactly one cycle, one cycle after push edge; issued_count=1.
REQ-033 Fill/full: push 0xA0..0xA4 with stall=1, DEPTH 4 -> in_ready=0 after 4th push, 0xA4 dropped, fifo_count=4; release stall -> issues 0xA0,0xA1,0xA2,0xA3 spaced by 1 idle cycle, never 0xA4.
REQ-034 Back-to-back: MIN_GAP 0, preload 3 entries 1,2,3, drop stall -> request high 3 consecutive cycles, input_data 1,2,3, fifo_count 0 after.
REQ-035 Simultaneous push/pop: fifo_count=2, push 0x55 on the same edge as an issue -> fifo_count stays 2, 0x55 issued last in order.
REQ-036 Mid-operation reset: fifo_count=3, request high, assert reset one edge -> request 0, input_data 0, fifo_count 0, issued_count 0; no stale entry issued afterwards.
REQ-037 Wrap: force 65536 issues -> issued_count returns to 0x0000; pointers wrap with order preserved.

Source files
------------

// File: rtl/async_req_issuer.sv
// async_req_issuer: FIFO-buffered command issuer with min-gap pacing and stall hold.
// Revision 1.0
`default_nettype none

module async_req_issuer #(
  parameter int DEPTH   = 4,
  parameter int MIN_GAP = 1
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         in_valid,
  input  logic [31:0]                  in_data,
  output logic                         in_ready,
  input  logic                         stall,
  output logic                         request,
  output logic [31:0]                  input_data,
  output logic [$clog2(DEPTH+1)-1:0]   fifo_count,
  output logic [15:0]                  issued_count
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int AW = $clog2(DEPTH);
  localparam int GW = (MIN_GAP > 0) ? $clog2(MIN_GAP + 1) : 1;
  localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);
  localparam logic [GW-1:0] GAP_RELOAD = GW'(MIN_GAP);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_GAP   = 2'd2;

  logic [1:0]    state;
  logic [31:0]   mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [GW-1:0] gap_cnt;
  logic [GW-1:0] gap_next;
  logic          push;
  logic          pop;

  // Ready depends only on the registered count, so a same-cycle pop never frees a slot early.
  assign in_ready = (fifo_count < FULL_COUNT);
  assign push     = in_valid && in_ready;
  assign pop      = (fifo_count != '0) && !stall && (gap_cnt == '0);
  assign request  = (state == ST_ISSUE);

  always_comb begin
    gap_next = gap_cnt;
    if (pop) begin
      gap_next = GAP_RELOAD;
    end else if (gap_cnt != '0) begin
      gap_next = gap_cnt - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push && !reset) begin
      mem[wr_ptr] <= in_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= ST_IDLE;
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      gap_cnt      <= '0;
      fifo_count   <= '0;
      input_data   <= '0;
      issued_count <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr       <= rd_ptr + 1'b1;
        input_data   <= mem[rd_ptr];
        issued_count <= issued_count + 16'd1;
      end
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + 1'b1;
        2'b01:   fifo_count <= fifo_count - 1'b1;
        default: fifo_count <= fifo_count;
      endcase
      gap_cnt <= gap_next;
      if (pop) begin
        state <= ST_ISSUE;
      end else if (gap_next != '0) begin
        state <= ST_GAP;
      end else begin
        state <= ST_IDLE;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_async_req_issuer.sv
// tb_async_req_issuer: scoreboard bench for async_req_issuer (MIN_GAP=1 and MIN_GAP=0 instances).
`default_nettype none

module tb_async_req_issuer;

  logic        clk = 1'b0;
  logic        reset;
  logic        v1, st1, rdy1, req1;
  logic [31:0] d1, dat1;
  logic [2:0]  cnt1;
  logic [15:0] iss1;
  logic        v0, st0, rdy0, req0;
  logic [31:0] d0, dat0;
  logic [2:0]  cnt0;
  logic [15:0] iss0;

  int n_vec = 0;
  int n_err = 0;
  logic [31:0] q1[$];
  logic [31:0] q0[$];
  logic prev1 = 1'b0;

  always #5 clk = ~clk;

  async_req_issuer #(.DEPTH(4), .MIN_GAP(1)) dut1 (
    .clk(clk), .reset(reset), .in_valid(v1), .in_data(d1), .in_ready(rdy1),
    .stall(st1), .request(req1), .input_data(dat1), .fifo_count(cnt1), .issued_count(iss1)
  );

  async_req_issuer #(.DEPTH(4), .MIN_GAP(0)) dut0 (
    .clk(clk), .reset(reset), .in_valid(v0), .in_data(d0), .in_ready(rdy0),
    .stall(st0), .request(req0), .input_data(dat0), .fifo_count(cnt0), .issued_count(iss0)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  task automatic push1(input logic [31:0] val, input bit expect_accept);
    v1 = 1'b1;
    d1 = val;
    if (expect_accept) q1.push_back(val);
    @(negedge clk);
  endtask

  task automatic push0(input logic [31:0] val);
    v0 = 1'b1;
    d0 = val;
    q0.push_back(val);
    @(negedge clk);
  endtask

  // Monitor: samples just after each active edge and pops the scoreboard on every pulse.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (req1) begin
        if (prev1) begin
          n_vec++;
          n_err++;
          $display("FAIL dut1 spacing: request high two cycles in a row, required at least one idle cycle");
        end
        if (q1.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL dut1 spurious request: got data %h, expected no request", dat1);
        end else begin
          chk("dut1 issue order", dat1, q1.pop_front());
        end
      end
      prev1 = req1;
      if (req0) begin
        if (q0.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL dut0 spurious request: got data %h, expected no request", dat0);
        end else begin
          chk("dut0 issue order", dat0, q0.pop_front());
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    v1 = 1'b0; d1 = '0; st1 = 1'b0;
    v0 = 1'b0; d0 = '0; st0 = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    // Reset state
    chk("reset request", 32'(req1), 32'd0);
    chk("reset input_data", dat1, 32'h0);
    chk("reset fifo_count", 32'(cnt1), 32'd0);
    chk("reset issued_count", 32'(iss1), 32'd0);
    chk("reset in_ready", 32'(rdy1), 32'd1);

    // Single command: request one cycle after the push edge, exactly one cycle wide
    push1(32'h10, 1'b1);
    v1 = 1'b0;
    chk("single no fall-through", 32'(req1), 32'd0);
    chk("single count after push", 32'(cnt1), 32'd1);
    @(negedge clk);
    chk("single request", 32'(req1), 32'd1);
    chk("single data", dat1, 32'h10);
    chk("single issued_count", 32'(iss1), 32'd1);
    @(negedge clk);
    chk("single pulse width", 32'(req1), 32'd0);
    chk("single data hold", dat1, 32'h10);

    // Fill to full under stall; fifth command dropped
    st1 = 1'b1;
    for (int i = 0; i < 4; i++) push1(32'hA0 + 32'(i), 1'b1);
    chk("full in_ready", 32'(rdy1), 32'd0);
    chk("full count", 32'(cnt1), 32'd4);
    push1(32'hA4, 1'b0);
    v1 = 1'b0;
    chk("full drop count", 32'(cnt1), 32'd4);
    chk("full stall no request", 32'(req1), 32'd0);
    st1 = 1'b0;
    repeat (12) @(negedge clk);
    chk("full drained count", 32'(cnt1), 32'd0);
    chk("full issued_count", 32'(iss1), 32'd5);
    chk("full scoreboard empty", 32'(q1.size()), 32'd0);

    // Simultaneous push and pop
    st1 = 1'b1;
    push1(32'h11, 1'b1);
    push1(32'h22, 1'b1);
    chk("simul pre count", 32'(cnt1), 32'd2);
    st1 = 1'b0;
    push1(32'h55, 1'b1);
    v1 = 1'b0;
    chk("simul count unchanged", 32'(cnt1), 32'd2);
    chk("simul request", 32'(req1), 32'd1);
    repeat (8) @(negedge clk);
    chk("simul drained", 32'(q1.size()), 32'd0);
    chk("simul issued_count", 32'(iss1), 32'd8);

    // Mid-operation reset flushes pending commands
    st1 = 1'b1;
    for (int i = 0; i < 4; i++) push1(32'h31 + 32'(i), 1'b1);
    v1 = 1'b0;
    st1 = 1'b0;
    @(negedge clk);
    chk("midreset pre count", 32'(cnt1), 32'd3);
    chk("midreset pre request", 32'(req1), 32'd1);
    reset = 1'b1;
    q1.delete();
    q0.delete();
    @(negedge clk);
    reset = 1'b0;
    chk("midreset request", 32'(req1), 32'd0);
    chk("midreset input_data", dat1, 32'h0);
    chk("midreset count", 32'(cnt1), 32'd0);
    chk("midreset issued_count", 32'(iss1), 32'd0);
    repeat (10) @(negedge clk);
    chk("midreset stays empty", 32'(cnt1), 32'd0);

    // Back-to-back with MIN_GAP=0
    st0 = 1'b1;
    push0(32'd1);
    push0(32'd2);
    push0(32'd3);
    v0 = 1'b0;
    st0 = 1'b0;
    @(negedge clk);
    chk("b2b req 1", 32'(req0), 32'd1);
    chk("b2b data 1", dat0, 32'd1);
    @(negedge clk);
    chk("b2b req 2", 32'(req0), 32'd1);
    chk("b2b data 2", dat0, 32'd2);
    @(negedge clk);
    chk("b2b req 3", 32'(req0), 32'd1);
    chk("b2b data 3", dat0, 32'd3);
    chk("b2b count", 32'(cnt0), 32'd0);
    @(negedge clk);
    chk("b2b req end", 32'(req0), 32'd0);
    chk("b2b issued_count", 32'(iss0), 32'd3);

    // issued_count wrap after 65536 issues; pointers wrap many times with order checked
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 65536; i++) push0(32'(i) * 32'd3 + 32'd7);
    v0 = 1'b0;
    repeat (4) @(negedge clk);
    chk("wrap issued_count", 32'(iss0), 32'd0);
    chk("wrap count", 32'(cnt0), 32'd0);
    chk("wrap last data", dat0, 32'd65535 * 32'd3 + 32'd7);
    chk("wrap scoreboard empty", 32'(q0.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
